video_pattern_gen: RTL and testbench

- Video stream transmitter: generates dv/hs/vs timing plus 8-bit RGB test patterns in the same stream format the sobel_top chain consumes.
- Drives the pipeline input in simulation and on board when no HDMI receiver is present.
- Also produces line_end_o, matching the rgb2y/buffer line-end convention.

---
 rtl/video_pattern_gen.sv | 177 +++++++++++++++++
 tb/tb_video_pattern_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Video timing and RGB test-pattern source (dv/hs/vs + line_end).
// Build option: define PATTERN_ANIM_EN to scroll the ramp and checkerboard by frame count.
module video_pattern_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pat_sel_i,
    input  logic [23:0] solid_i,
    output logic [7:0]  red_o,
    output logic [7:0]  green_o,
    output logic [7:0]  blue_o,
    output logic        dv_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic        line_end_o,
    output logic [7:0]  frame_cnt_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are at least 8/6 bits wide so x[7:0] and y[5] always exist.
    localparam int unsigned HW = ($clog2(H_TOTAL) < 8) ? 8 : $clog2(H_TOTAL);
    localparam int unsigned VW = ($clog2(V_TOTAL) < 6) ? 6 : $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam int unsigned   BAR_W    = H_ACTIVE / 8;
    localparam int unsigned   BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [BW-1:0] bar_px;
    logic [2:0]    bar_idx;
    logic [1:0]    pat_q;
    logic [23:0]   solid_q;

    logic          h_wrap;
    logic          v_wrap;
    logic          frame_wrap;
    logic          act;
    logic          hs_d;
    logic          vs_d;
    logic          le_d;
    logic [7:0]    x_eff;
    logic [7:0]    pix_r;
    logic [7:0]    pix_g;
    logic [7:0]    pix_b;

    assign h_wrap     = (h_cnt == H_LAST);
    assign v_wrap     = (v_cnt == V_LAST);
    assign frame_wrap = h_wrap && v_wrap;

`ifdef PATTERN_ANIM_EN
    assign x_eff = h_cnt[7:0] + frame_cnt_o;
`else
    assign x_eff = h_cnt[7:0];
`endif

    // Raster position: h runs every clock, v steps on each line wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end
        end
    end

    // Colour-bar index tracks h_cnt with a pixel-in-bar count, avoiding a divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_wrap) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (bar_px == BAR_LAST) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 1'b1;
        end else begin
            bar_px  <= bar_px + 1'b1;
        end
    end

    // Pattern selection and frame count only change on the frame wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q       <= 2'd0;
            solid_q     <= '0;
            frame_cnt_o <= '0;
        end else if (frame_wrap) begin
            pat_q       <= pat_sel_i;
            solid_q     <= solid_i;
            frame_cnt_o <= frame_cnt_o + 1'b1;
        end
    end

    // Timing decode and pixel colour for the current raster position.
    always_comb begin
        act   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_d  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_d  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        le_d  = act && (h_cnt == H_ACT_LAST);
        pix_r = 8'h00;
        pix_g = 8'h00;
        pix_b = 8'h00;
        if (act) begin
            unique case (pat_q)
                2'd0: begin
                    pix_r = {8{~bar_idx[1]}};
                    pix_g = {8{~bar_idx[2]}};
                    pix_b = {8{~bar_idx[0]}};
                end
                2'd1: begin
                    pix_r = x_eff;
                    pix_g = x_eff;
                    pix_b = x_eff;
                end
                2'd2: begin
                    pix_r = {8{x_eff[5] ^ v_cnt[5]}};
                    pix_g = {8{x_eff[5] ^ v_cnt[5]}};
                    pix_b = {8{x_eff[5] ^ v_cnt[5]}};
                end
                2'd3: begin
                    pix_r = solid_q[23:16];
                    pix_g = solid_q[15:8];
                    pix_b = solid_q[7:0];
                end
            endcase
        end
    end

    // Register every stream output one clock behind the counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red_o      <= '0;
            green_o    <= '0;
            blue_o     <= '0;
            dv_o       <= 1'b0;
            hs_o       <= ~SYNC_POL;
            vs_o       <= ~SYNC_POL;
            line_end_o <= 1'b0;
        end else begin
            red_o      <= pix_r;
            green_o    <= pix_g;
            blue_o     <= pix_b;
            dv_o       <= act;
            hs_o       <= hs_d ? SYNC_POL : ~SYNC_POL;
            vs_o       <= vs_d ? SYNC_POL : ~SYNC_POL;
            line_end_o <= le_d;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen on a 24x12 raster.
// A reference model queues expected outputs per edge; a negedge checker pops them.
module tb_video_pattern_gen;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 8;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam bit SP = 1'b1;
`ifdef PATTERN_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  pat_sel = 2'd0;
    logic [23:0] solid = 24'h0;
    logic [7:0]  red_o;
    logic [7:0]  green_o;
    logic [7:0]  blue_o;
    logic        dv_o;
    logic        hs_o;
    logic        vs_o;
    logic        line_end_o;
    logic [7:0]  frame_cnt_o;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(SP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pat_sel_i(pat_sel),
        .solid_i(solid),
        .red_o(red_o),
        .green_o(green_o),
        .blue_o(blue_o),
        .dv_o(dv_o),
        .hs_o(hs_o),
        .vs_o(vs_o),
        .line_end_o(line_end_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          h;
        int          v;
        int          frame;
        logic [23:0] rgb;
        logic [3:0]  ctl;
        logic [7:0]  fc;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    exp_t ce;

    int n_checks = 0;
    int n_fail = 0;

    int          mh = 0;
    int          mv = 0;
    int          mframe = 0;
    logic [7:0]  mfc = 8'h0;
    logic [1:0]  mpat = 2'd0;
    logic [23:0] msolid = 24'h0;
    logic        m_dv;
    logic        m_hs;
    logic        m_vs;
    logic        m_le;
    bit          after_rst = 1'b0;
    bit          hit = 1'b0;

    int dv_run = 0;
    int le_run = 0;
    int dv_lines = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_red"}, {24'h0, red_o}, 32'h0);
        check({p, "_green"}, {24'h0, green_o}, 32'h0);
        check({p, "_blue"}, {24'h0, blue_o}, 32'h0);
        check({p, "_dv"}, {31'h0, dv_o}, 32'h0);
        check({p, "_hs"}, {31'h0, hs_o}, {31'h0, ~SP});
        check({p, "_vs"}, {31'h0, vs_o}, {31'h0, ~SP});
        check({p, "_le"}, {31'h0, line_end_o}, 32'h0);
        check({p, "_fc"}, {24'h0, frame_cnt_o}, 32'h0);
    endtask

    function automatic logic [23:0] model_rgb(input int x, input int y,
                                              input logic [1:0] pat,
                                              input logic [23:0] sol,
                                              input logic [7:0] fc);
        logic [7:0] xe;
        xe = 8'(x) + (ANIM ? fc : 8'h0);
        case (pat)
            2'd0: begin
                case (x / (HA / 8))
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'd1: return {xe, xe, xe};
            2'd2: return (xe[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
            default: return sol;
        endcase
    endfunction

    // Reference model: one expected entry per active clock edge.
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            sbq.delete();
            mh = 0;
            mv = 0;
            mframe = 0;
            mfc = 8'h0;
            mpat = 2'd0;
            msolid = 24'h0;
        end else begin
            m_dv = (mh < HA) && (mv < VA);
            m_hs = (mh >= HA + HF && mh < HA + HF + HS) ? SP : ~SP;
            m_vs = (mv >= VA + VF && mv < VA + VF + VS) ? SP : ~SP;
            m_le = m_dv && (mh == HA - 1);
            me.h = mh;
            me.v = mv;
            me.frame = mframe;
            me.rgb = m_dv ? model_rgb(mh, mv, mpat, msolid, mfc) : 24'h0;
            me.ctl = {m_dv, m_hs, m_vs, m_le};
            if (mh == HT - 1 && mv == VT - 1) begin
                mfc = mfc + 8'd1;
                mpat = pat_sel;
                msolid = solid;
                mframe++;
            end
            me.fc = mfc;
            sbq.push_back(me);
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
    end

    // Checker: compare DUT outputs against the oldest expected entry.
    initial forever begin
        @(negedge clk);
        if (sbq.size() > 0) begin
            ce = sbq.pop_front();
            check("rgb", {8'h0, red_o, green_o, blue_o}, {8'h0, ce.rgb});
            check("ctl", {28'h0, dv_o, hs_o, vs_o, line_end_o},
                  {28'h0, ce.ctl});
            check("frame_cnt", {24'h0, frame_cnt_o}, {24'h0, ce.fc});

            if (ce.h == 0) begin
                dv_run = 0;
                le_run = 0;
                if (ce.v == 0) dv_lines = 0;
            end
            dv_run += int'(dv_o);
            le_run += int'(line_end_o);
            if (ce.h == HT - 1) begin
                if (dv_run > 0) dv_lines++;
                check("dv_per_line", dv_run, (ce.v < VA) ? HA : 0);
                check("le_per_line", le_run, (ce.v < VA) ? 1 : 0);
                if (ce.v == VT - 1) check("dv_lines", dv_lines, VA);
            end

            if (!after_rst && ce.frame == 0 && ce.v == 0) begin
                case (ce.h)
                    0:  check("bar_white", {8'h0, red_o, green_o, blue_o}, 32'hFFFFFF);
                    3:  check("bar_yellow", {8'h0, red_o, green_o, blue_o}, 32'hFFFF00);
                    5:  check("bar_cyan", {8'h0, red_o, green_o, blue_o}, 32'h00FFFF);
                    7:  check("bar_green", {8'h0, red_o, green_o, blue_o}, 32'h00FF00);
                    9:  check("bar_magenta", {8'h0, red_o, green_o, blue_o}, 32'hFF00FF);
                    10: check("bar_red", {8'h0, red_o, green_o, blue_o}, 32'hFF0000);
                    13: check("bar_blue", {8'h0, red_o, green_o, blue_o}, 32'h0000FF);
                    15: check("bar_black", {8'h0, red_o, green_o, blue_o}, 32'h000000);
                    20: check("blank_rgb", {8'h0, red_o, green_o, blue_o}, 32'h000000);
                    default: ;
                endcase
            end
            if (!after_rst && ce.frame == 1 && ce.h < HA && ce.v < VA)
                check("checker_f1", {8'h0, red_o, green_o, blue_o}, 32'h0);
            if (!after_rst && ce.frame == 2 && ce.h < HA && ce.v < VA)
                check("solid_f2", {8'h0, red_o, green_o, blue_o}, 32'h123456);
            if (!after_rst && ce.frame == 254 && ce.h == HT - 1 && ce.v == VT - 1)
                check("fc_255", {24'h0, frame_cnt_o}, 32'd255);
            if (!after_rst && ce.frame == 255 && ce.h == HT - 1 && ce.v == VT - 1)
                check("fc_wrap", {24'h0, frame_cnt_o}, 32'd0);
            if (after_rst && ce.frame == 1 && ce.v == 0 && ce.h == 0)
                check("anim_f1_x0", {24'h0, red_o}, ANIM ? 32'h01 : 32'h00);
            if (after_rst && ce.frame == 3 && ce.v == 0 && ce.h == 5)
                check("anim_f3_x5", {24'h0, red_o}, ANIM ? 32'h08 : 32'h05);
        end
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b1;

        repeat (3 * HT) @(negedge clk);
        pat_sel = 2'd2;
        repeat (FT) @(negedge clk);
        pat_sel = 2'd3;
        solid = 24'h123456;
        repeat (FT) @(negedge clk);
        pat_sel = 2'd1;
        for (int f = 3; f <= 256; f++) begin
            repeat (FT) @(negedge clk);
            pat_sel = 2'($urandom_range(0, 3));
            solid = 24'($urandom);
        end

        hit = 1'b0;
        for (int i = 0; i < 2 * FT && !hit; i++) begin
            @(negedge clk);
            if (mh == 8 && mv == 4) hit = 1'b1;
        end
        if (!hit) check("rst_pos_timeout", 32'd0, 32'd1);
        #2 rst = 1'b0;
        #1 check_reset("arst");
        pat_sel = 2'd1;
        after_rst = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_dv", {31'h0, dv_o}, 32'd1);
        check("post_rst_fc", {24'h0, frame_cnt_o}, 32'd0);
        check("post_rst_rgb", {8'h0, red_o, green_o, blue_o}, 32'hFFFFFF);
        repeat (4 * FT + 10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
